// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants: candidate source indices, the default reset
// address and the redirect-buffer state type.
package fetch_pkg;

    localparam int SRC_SEQ    = 0;
    localparam int SRC_BRANCH = 1;
    localparam int SRC_JUMP   = 2;
    localparam int SRC_EXC    = 3;

    localparam int DEFAULT_RESET_ADDR = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } pend_state_e;

endpackage : fetch_pkg

// File: rtl/mux_nto1.sv
// Combinational N-to-1 selector over a packed candidate bus.
// Out-of-range indices fall back to the sequential source.
module mux_nto1
    import fetch_pkg::*;
#(
    parameter int bus_size = 10,
    parameter int N_SRC    = 4,
    localparam int SEL_W   = $clog2(N_SRC)
) (
    input  logic [N_SRC*bus_size-1:0] in_bus,
    input  logic [SEL_W-1:0]          idx,
    output logic [bus_size-1:0]       out
);

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
        out = in_bus[SRC_SEQ*bus_size +: bus_size];
        for (int k = 1; k < N_SRC; k++) begin
            if (idx == SEL_W'(k)) begin
                out = in_bus[k*bus_size +: bus_size];
            end
        end
    end

endmodule : mux_nto1

// File: rtl/pc_sel_mux_reg.sv
// Registered next-fetch-address selector with stall hold. Define
// PC_SEL_PENDING_EN to buffer redirect requests that arrive during a stall.
module pc_sel_mux_reg
    import fetch_pkg::*;
#(
    parameter int                 bus_size   = 10,
    parameter int                 N_SRC      = 4,
    parameter logic [bus_size-1:0] RESET_ADDR = bus_size'(DEFAULT_RESET_ADDR),
    localparam int                SEL_W      = $clog2(N_SRC)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_SRC*bus_size-1:0] in_bus,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      sel_valid,
    input  logic                      stall,
    output logic [bus_size-1:0]       out,
    output logic                      redirect_pending
);

    logic                sel_legal;
    logic [SEL_W-1:0]    src_idx;
    logic [bus_size-1:0] mux_out;

    // An illegal index behaves as a sequential fetch and is never buffered.
    assign sel_legal = ({1'b0, sel} < (SEL_W+1)'(N_SRC));

`ifdef PC_SEL_PENDING_EN
    pend_state_e      state_q, state_d;
    logic [SEL_W-1:0] pend_idx_q, pend_idx_d;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q    <= IDLE;
            pend_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    // Last request within a stall wins; any non-stall edge drains the buffer.
    always_comb begin
        state_d    = state_q;
        pend_idx_d = pend_idx_q;
        if (!stall) begin
            state_d = IDLE;
        end else if (sel_valid && sel_legal) begin
            state_d    = PENDING;
            pend_idx_d = sel;
        end
    end

    assign redirect_pending = (state_q == PENDING);

    // A live request beats a buffered one, even when the live index is illegal.
    always_comb begin
        src_idx = SEL_W'(SRC_SEQ);
        if (sel_valid) begin
            if (sel_legal) src_idx = sel;
        end else if (state_q == PENDING) begin
            src_idx = pend_idx_q;
        end
    end
`else
    always_comb begin
        src_idx = SEL_W'(SRC_SEQ);
        if (sel_valid && sel_legal) src_idx = sel;
    end

    assign redirect_pending = 1'b0;
`endif

    mux_nto1 #(
        .bus_size (bus_size),
        .N_SRC    (N_SRC)
    ) u_mux (
        .in_bus (in_bus),
        .idx    (src_idx),
        .out    (mux_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= RESET_ADDR;
        end else if (!stall) begin
            out <= mux_out;
        end
    end

endmodule : pc_sel_mux_reg

// File: doc/pc_sel_mux_reg.md
# pc_sel_mux_reg

Registered, parametrised N-to-1 next-address selector for the instruction-fetch stage. It chooses among N_SRC candidate addresses: sequential, branch target, jump target and exception vector. The choice is held in an internal address register that drives instruction memory. It adds stall hold and buffering of redirect requests that arrive while the fetch stage is stalled.

## Interface
Parameters:
- bus_size, 10, width of every address bus and of the output.
- N_SRC, 4, number of candidate inputs (2..8).
- RESET_ADDR, 0, value loaded into the address register on reset.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- in_bus  in  N_SRC*bus_size  packed candidates; source k occupies bits [k*bus_size +: bus_size]; source 0 is sequential (PC+4).
- sel  in  clog2(N_SRC)  encoded source index for a redirect.
- sel_valid  in  1  a redirect request is present this cycle.
- stall  in  1  fetch stage frozen; the address register holds.
- out  out  bus_size  registered next fetch address.
- redirect_pending  out  1  a redirect is buffered, awaiting release of stall.

## Operation
- Reset has top priority. In the cycle reset is sampled high:
  - out <= RESET_ADDR;
  - redirect_pending <= 0;
  - the pending index is cleared.
- Non-stall cycle, stall=0. The source index used is, in priority order:
  - sel, if sel_valid=1 (a live request beats a buffered one);
  - the buffered index, if redirect_pending=1;
  - 0 otherwise.
  - out <= in_bus slice of the chosen index; redirect_pending <= 0.
- Stall cycle, stall=1:
  - out holds.
  - If sel_valid=1, the index sel is captured in the pending register and redirect_pending <= 1.
  - A later request during the same stall overwrites the earlier one (last-wins).
  - Only the index is buffered, not the address. The target input must remain valid until release.
- sel ≥ N_SRC is illegal. Such a request is treated as index 0 and never buffered.
- State: IDLE (redirect_pending=0) and PENDING (redirect_pending=1).
  - IDLE→PENDING on stall & sel_valid.
  - PENDING→IDLE on !stall, or on reset.
  - PENDING→PENDING on stall (index updated if sel_valid).
- Width rule: out is exactly bus_size; no truncation or extension is performed.

## Timing
- Latency: 1 cycle from the sel/sel_valid/in_bus sample to out.
- Buffered redirect: applied on the first rising edge with stall=0, with out updated after that edge.
- redirect_pending is registered. It rises in the cycle after the capturing edge and falls after the releasing edge.
- Reset asserted mid-stall with a pending redirect discards the redirect. The first post-reset cycle then behaves as IDLE.
- Reset and stall together: reset wins; out=RESET_ADDR.

## Configuration
- PC_SEL_PENDING_EN defined: the pending buffer and redirect_pending are as described.
- PC_SEL_PENDING_EN undefined:
  - no pending register is built;
  - redirect_pending is tied to 0;
  - sel_valid during stall is ignored, and the requester must hold the request until stall drops;
  - non-stall behaviour is identical.

## Structure
- Shared package fetch_pkg holds:
  - source index constants SRC_SEQ=0, SRC_BRANCH=1, SRC_JUMP=2, SRC_EXC=3;
  - the default RESET_ADDR.
- One sub-module, mux_nto1: purely combinational selection of in_bus by index, parametrised on bus_size and N_SRC. pc_sel_mux_reg adds the register, the stall logic and the pending logic around it.

## Test plan
- Reset: reset=1 for 2 cycles with RESET_ADDR=0x010 -> out=0x010 and redirect_pending=0 after the first edge.
- Sequential: in_bus src0=0x004, sel_valid=0, stall=0 -> out=0x004 one cycle later; holds 0x004 while stall=1.
- Direct redirect: src2=0x2A0, sel=2, sel_valid=1, stall=0 -> out=0x2A0 next cycle; redirect_pending stays 0.
- Buffered redirect, last-wins:
  - stall=1 for 3 cycles, with sel=1 (src1=0x100) in cycle 1 and sel=3 (src3=0x3F0) in cycle 2 -> redirect_pending=1 and out unchanged;
  - stall drops -> out=0x3F0 and redirect_pending=0.
- Reset mid-pending: pending index 1 buffered, then reset=1 while stall=1 -> out=RESET_ADDR, redirect_pending=0; release stall -> out=src0.
- Illegal index and macro off:
  - N_SRC=3, sel=3, sel_valid=1 -> out=src0.
  - With PC_SEL_PENDING_EN undefined, repeat the buffered-redirect scenario -> out=src0 after release and redirect_pending always 0.
